// File: rtl/pwm_capture_if.sv
// PWM capture bus: the waveform into the capture block and the measurement results back out.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             Pwm_in;
  logic [CNT_W-1:0] Period_out;
  logic [CNT_W-1:0] High_out;
  logic             Valid_out;
  logic             Timeout_out;

  modport master (
    output Pwm_in,
    input  Period_out,
    input  High_out,
    input  Valid_out,
    input  Timeout_out
  );

  modport slave (
    input  Pwm_in,
    output Period_out,
    output High_out,
    output Valid_out,
    output Timeout_out
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in Clock_in cycles,
// with a one-cycle result strobe and a stalled-input timeout flag.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65000
) (
  input  logic           Clock_in,
  input  logic           Reset,
  pwm_capture_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t           state;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic             timeout_hit;

  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.Pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise        = s2 & ~s3;
  assign fall        = ~s2 & s3;
  assign timeout_hit = (cnt == TO_CNT);

  // Restarts at 1 on each rise so the value seen at the closing edge equals the cycle count.
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      hi_cnt          <= '0;
      bus.Period_out  <= '0;
      bus.High_out    <= '0;
      bus.Valid_out   <= 1'b0;
      bus.Timeout_out <= 1'b0;
    end else begin
      bus.Valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state           <= HIGH;
            bus.Timeout_out <= 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            state  <= LOW;
            hi_cnt <= cnt;
          end else if (timeout_hit) begin
            state           <= IDLE;
            bus.Timeout_out <= 1'b1;
          end
        end
        LOW: begin
          // An edge coinciding with the timeout count takes priority.
          if (rise) begin
            state          <= HIGH;
            bus.Period_out <= cnt;
            bus.High_out   <= hi_cnt;
            bus.Valid_out  <= 1'b1;
          end else if (timeout_hit) begin
            state           <= IDLE;
            bus.Timeout_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: waveforms are driven one clock per step and the
// strobe/timeout step numbers are compared against hand-derived values.
module tb_pwm_capture;

  localparam int CNT_W = 16;
  localparam int TO    = 1000;

  logic clk;
  logic rst;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TO)
  ) dut (
    .Clock_in (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nerr = 0;

  int step_no = 0;
  int nvalid, first_valid, last_valid, wide_valid;
  int first_p, first_h;
  int to_first, to_clear, to_count;
  logic prev_to = 1'b0;
  logic prev_valid = 1'b0;

  int a0, b0, c0, d0, e0, f0, g0, h0, i0, lo0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    nvalid      = 0;
    first_valid = -1;
    last_valid  = -1;
    wide_valid  = 0;
    first_p     = -1;
    first_h     = -1;
    to_first    = -1;
    to_clear    = -1;
    to_count    = 0;
  endtask

  // One clock: drive Pwm_in, wait past the edge, then log strobe and timeout activity.
  task automatic step(input logic v);
    step_no++;
    bus.Pwm_in = v;
    @(posedge clk);
    #1;
    if (bus.Valid_out === 1'b1) begin
      nvalid++;
      if (prev_valid) wide_valid++;
      if (first_valid < 0) begin
        first_valid = step_no;
        first_p     = int'(bus.Period_out);
        first_h     = int'(bus.High_out);
      end
      last_valid = step_no;
    end
    if (bus.Timeout_out === 1'b1) begin
      to_count++;
      if (to_first < 0) to_first = step_no;
    end else if (prev_to) begin
      to_clear = step_no;
    end
    prev_to    = (bus.Timeout_out === 1'b1);
    prev_valid = (bus.Valid_out === 1'b1);
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) step(1'b1);
      for (int i = 0; i < l; i++) step(1'b0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.Pwm_in = 1'b0;
    clear_stats();
    #1;
    check("reset_period",  32'(bus.Period_out),  32'd0);
    check("reset_high",    32'(bus.High_out),    32'd0);
    check("reset_valid",   32'(bus.Valid_out),   32'd0);
    check("reset_timeout", 32'(bus.Timeout_out), 32'd0);
    repeat (3) step(1'b0);
    rst = 1'b0;
    repeat (5) step(1'b0);
    check("idle_no_timeout", 32'(to_count), 32'd0);

    // Steady 40/60.
    clear_stats();
    a0 = step_no + 1;
    wave(40, 60, 3);
    check("t1_nvalid",      32'(nvalid),      32'd2);
    check("t1_first_valid", 32'(first_valid), 32'(a0 + 102));
    check("t1_last_valid",  32'(last_valid),  32'(a0 + 202));
    check("t1_period",      32'(bus.Period_out), 32'd100);
    check("t1_high",        32'(bus.High_out),   32'd40);
    check("t1_width",       32'(wide_valid),  32'd0);

    // Minimum high time, then near-full duty.
    clear_stats();
    b0 = step_no + 1;
    wave(2, 98, 2);
    check("t2a_first_p",    32'(first_p),     32'd100);
    check("t2a_first_h",    32'(first_h),     32'd40);
    check("t2a_last_valid", 32'(last_valid),  32'(b0 + 102));
    check("t2a_period",     32'(bus.Period_out), 32'd100);
    check("t2a_high",       32'(bus.High_out),   32'd2);
    clear_stats();
    c0 = step_no + 1;
    wave(98, 2, 2);
    check("t2b_first_h",    32'(first_h),     32'd2);
    check("t2b_last_valid", 32'(last_valid),  32'(c0 + 102));
    check("t2b_period",     32'(bus.Period_out), 32'd100);
    check("t2b_high",       32'(bus.High_out),   32'd98);

    // 50/50 then stuck high.
    d0 = step_no + 1;
    wave(50, 50, 2);
    clear_stats();
    repeat (TO + 20) step(1'b1);
    check("t3_nvalid",      32'(nvalid),      32'd1);
    check("t3_last_valid",  32'(last_valid),  32'(d0 + 202));
    check("t3_to_first",    32'(to_first),    32'(d0 + 202 + TO));
    check("t3_to_level",    32'(bus.Timeout_out), 32'd1);
    check("t3_period",      32'(bus.Period_out),  32'd100);
    check("t3_high",        32'(bus.High_out),    32'd50);

    // Recovery with 100/100.
    clear_stats();
    lo0 = step_no + 1;
    repeat (100) step(1'b0);
    e0 = step_no + 1;
    wave(100, 100, 2);
    check("t4_to_held",     32'(to_first),    32'(lo0));
    check("t4_to_clear",    32'(to_clear),    32'(e0 + 2));
    check("t4_nvalid",      32'(nvalid),      32'd1);
    check("t4_last_valid",  32'(last_valid),  32'(e0 + 202));
    check("t4_period",      32'(bus.Period_out), 32'd200);
    check("t4_high",        32'(bus.High_out),   32'd100);

    // Reset mid-high.
    f0 = step_no + 1;
    repeat (20) step(1'b1);
    check("t5_pre_period",  32'(bus.Period_out), 32'd200);
    rst = 1'b1;
    #1;
    check("t5_rst_period",  32'(bus.Period_out),  32'd0);
    check("t5_rst_high",    32'(bus.High_out),    32'd0);
    check("t5_rst_valid",   32'(bus.Valid_out),   32'd0);
    check("t5_rst_timeout", 32'(bus.Timeout_out), 32'd0);
    repeat (3) step(1'b1);
    rst = 1'b0;
    clear_stats();
    g0 = step_no + 1;
    wave(10, 50, 1);
    wave(30, 70, 2);
    check("t5_nvalid",      32'(nvalid),      32'd2);
    check("t5_first_valid", 32'(first_valid), 32'(g0 + 62));
    check("t5_first_p",     32'(first_p),     32'd60);
    check("t5_first_h",     32'(first_h),     32'd10);
    check("t5_last_valid",  32'(last_valid),  32'(g0 + 162));
    check("t5_period",      32'(bus.Period_out), 32'd100);
    check("t5_high",        32'(bus.High_out),   32'd30);

    // Longest period below the timeout, then stuck low.
    clear_stats();
    h0 = step_no + 1;
    wave(499, 500, 3);
    check("t6_nvalid",      32'(nvalid),      32'd3);
    check("t6_last_valid",  32'(last_valid),  32'(h0 + 2000));
    check("t6_no_timeout",  32'(to_count),    32'd0);
    check("t6_period",      32'(bus.Period_out), 32'd999);
    check("t6_high",        32'(bus.High_out),   32'd499);
    repeat (20) step(1'b0);
    check("t6_low_to_first", 32'(to_first),   32'(h0 + 2000 + TO));
    check("t6_held_period",  32'(bus.Period_out), 32'd999);

    // Period equal to TIMEOUT: the closing rise beats the timeout.
    clear_stats();
    i0 = step_no + 1;
    wave(500, 500, 3);
    check("t7_to_count",    32'(to_count),    32'd2);
    check("t7_to_clear",    32'(to_clear),    32'(i0 + 2));
    check("t7_nvalid",      32'(nvalid),      32'd2);
    check("t7_last_valid",  32'(last_valid),  32'(i0 + 2002));
    check("t7_period",      32'(bus.Period_out), 32'd1000);
    check("t7_high",        32'(bus.High_out),   32'd500);
    check("t7_width",       32'(wide_valid),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
